// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Groups the request/response handshake of the core's memory stage and the
// word-addressed data memory bus that the load/store unit drives.
//
// Signals:
//   req_valid, req_we, req_size[1:0], req_unsigned, req_addr[31:0],
//   req_wdata[31:0]                 : request from the core
//   req_ready                       : unit can accept a request
//   rsp_valid, rsp_rdata[31:0],
//   rsp_err                         : one-cycle response back to the core
//   mem_addr[31:0], mem_din[31:0],
//   mem_we, mem_re                  : word access towards the memory
//   mem_dout[31:0]                  : combinational read data from the memory
//
// Modports:
//   slave  : the load/store unit itself
//   master : its environment (core request side plus the memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_din, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_din, mem_we, mem_re
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts byte-addressed byte/halfword/word loads and stores into accesses of
// a word-addressed memory. Sub-word stores use a read-modify-write sequence;
// sub-word loads are lane-extracted and sign- or zero-extended.
//
// Parameters:
//   MEM_WORDS : depth of the attached memory in 32-bit words
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.slave (request, response and memory signals)
//
// Configuration macro:
//   LSU_BOUNDS_CHECK_EN : when defined, requests whose word index is
//                         >= MEM_WORDS are rejected with rsp_err.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BoundsCheck = 1'b1;
`else
    localparam bit BoundsCheck = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        err_q;

    logic        out_of_range;
    logic        req_bad;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic        ready_c;
    logic        re_c;
    logic        we_c;
    logic        valid_c;
    logic        access_c;

    // Range check only exists when the bounds-check build is selected.
    assign out_of_range = BoundsCheck &&
                          ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));

    // Requests rejected at acceptance: illegal size or misalignment.
    assign req_bad = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                     out_of_range;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        re_c       = 1'b0;
        we_c       = 1'b0;
        valid_c    = 1'b0;
        access_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (req_bad)                    state_next = RESP;
                    else if (!bus.req_we)           state_next = LOAD;
                    else if (bus.req_size == 2'b10) state_next = WRITE;
                    else                            state_next = RMW_RD;
                end
            end
            LOAD: begin
                re_c       = 1'b1;
                access_c   = 1'b1;
                state_next = RESP;
            end
            RMW_RD: begin
                re_c       = 1'b1;
                access_c   = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                we_c       = 1'b1;
                access_c   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                valid_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Little-endian lane selection and extension of the read word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = bus.mem_dout[7:0];
            2'd1:    byte_lane = bus.mem_dout[15:8];
            2'd2:    byte_lane = bus.mem_dout[23:16];
            default: byte_lane = bus.mem_dout[31:24];
        endcase
        half_lane = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        case (size_q)
            2'b00:   load_value = unsigned_q ? {24'h0, byte_lane}
                                             : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_value = unsigned_q ? {16'h0, half_lane}
                                             : {{16{half_lane[15]}}, half_lane};
            default: load_value = bus.mem_dout;
        endcase
    end

    // Old word with the addressed lane replaced by the store data.
    always_comb begin
        merged_word = bus.mem_dout;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged_word[31:16] = wdata_q[15:0];
        end else begin
            merged_word[15:0] = wdata_q[15:0];
        end
    end

    // Request latch and datapath. wdata_q is reused to hold the merged word
    // so WRITE always drives wdata_q. rsp_rdata only changes on the edge that
    // enters RESP, so it holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        err_q      <= req_bad;
                        if (req_bad) rdata_q <= '0;
                    end
                end
                LOAD:    rdata_q <= load_value;
                RMW_RD:  wdata_q <= merged_word;
                WRITE:   rdata_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.mem_re    = re_c;
    assign bus.mem_we    = we_c;
    assign bus.rsp_valid = valid_c;
    assign bus.rsp_err   = valid_c && err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_addr  = access_c ? {2'b00, addr_q[31:2]} : 32'h0;
    assign bus.mem_din   = we_c ? wdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: a 256-word memory, a transaction
// level reference model producing per-cycle expectations, a per-cycle compare
// process, and directed requests with hand-computed results.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ready;
        bit          valid;
        bit          err;
        bit          we;
        bit          re;
        bit          commit;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] tb_mem    [256];
    logic [31:0] model_mem [256];
    exp_t        exp_q [$];
    bit          cur_idle = 1'b1;
    logic [31:0] held_rdata = 32'h0;
    int          checks = 0;
    int          passes = 0;

    // Memory: combinational read, write on the rising edge.
    assign bus.mem_dout = (bus.mem_addr < 32'd256) ? tb_mem[bus.mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 32'd256)
            tb_mem[bus.mem_addr[7:0]] <= bus.mem_din;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: what each cycle after acceptance must look like.
    function automatic void modelAccept(input bit we, input logic [1:0] size, input bit uns,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] idx   = addr >> 2;
        logic [31:0] old   = (idx < 256) ? model_mem[idx[7:0]] : 32'h0;
        int          shift = (size == 2'b00) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
        logic [31:0] v     = old >> shift;
        logic [31:0] mask  = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << shift;
        logic [31:0] r;
        bit          bad;
        bad = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
              (size == 2'b10 && addr % 4 != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        if (idx >= 256) bad = 1'b1;
`endif
        e = '{default: '0};
        if (bad) begin
            e.valid = 1; e.err = 1; e.rdata = 0;
            exp_q.push_back(e);
        end else if (!we) begin
            if (size == 2'b00)
                r = uns ? (v & 32'hFF) : (v[7] ? (v | 32'hFFFFFF00) : (v & 32'hFF));
            else if (size == 2'b01)
                r = uns ? (v & 32'hFFFF) : (v[15] ? (v | 32'hFFFF0000) : (v & 32'hFFFF));
            else
                r = old;
            e.re = 1; e.addr = idx;
            exp_q.push_back(e);
            e = '{default: '0};
            e.valid = 1; e.rdata = r;
            exp_q.push_back(e);
        end else begin
            if (size != 2'b10) begin
                e.re = 1; e.addr = idx;
                exp_q.push_back(e);
                e = '{default: '0};
                e.din = (old & ~mask) | ((wdata << shift) & mask);
            end else begin
                e.din = wdata;
            end
            e.we = 1; e.addr = idx; e.commit = 1;
            exp_q.push_back(e);
            e = '{default: '0};
            e.valid = 1; e.rdata = 0;
            exp_q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst && cur_idle && bus.req_valid)
            modelAccept(bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata);
    end

    // Reset drops anything in flight with no response.
    always @(posedge rst) begin
        exp_q.delete();
        cur_idle   = 1'b1;
        held_rdata = 32'h0;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            e = '{default: '0};
            e.ready = 1;
            cur_idle = 1'b1;
        end else begin
            e = exp_q.pop_front();
            cur_idle = 1'b0;
        end
        if (e.valid) held_rdata = e.rdata;
        checkOutput("req_ready", 32'(bus.req_ready), 32'(e.ready));
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(e.valid));
        checkOutput("rsp_err",   32'(bus.rsp_err),   32'(e.err));
        checkOutput("mem_we",    32'(bus.mem_we),    32'(e.we));
        checkOutput("mem_re",    32'(bus.mem_re),    32'(e.re));
        checkOutput("mem_addr",  bus.mem_addr,       e.addr);
        checkOutput("rsp_rdata", bus.rsp_rdata,      held_rdata);
        if (e.we) checkOutput("mem_din", bus.mem_din, e.din);
        if (e.commit && e.addr < 256) model_mem[e.addr[7:0]] = e.din;
    end

    // One request; reports what the response looked like.
    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic err, output logic [31:0] rdata,
                                 output int lat, output logic [31:0] seen_addr,
                                 output int we_cycles);
        bit found = 0;
        err = 0; rdata = 0; lat = 0; seen_addr = 0; we_cycles = 0;
        @(posedge clk); #2;
        bus.req_valid = 1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #2;
        bus.req_valid = 0;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_re || bus.mem_we) seen_addr = bus.mem_addr;
            if (bus.mem_we) we_cycles++;
            if (bus.rsp_valid) begin
                found = 1; lat = c; err = bus.rsp_err; rdata = bus.rsp_rdata;
            end
        end
        checkOutput("response_seen", 32'(found), 32'd1);
    endtask

    // Request interrupted by a reset pulse during cycle 1 after acceptance.
    task automatic resetDuring(input bit we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #2;
        bus.req_valid = 1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = 0; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #2;
        bus.req_valid = 0;
        checkOutput("pre_reset_access", 32'(we && size == 2'b10 ? bus.mem_we : bus.mem_re), 32'd1);
        #1 rst = 1;
        #1;
        checkOutput("reset_we_drop", 32'(bus.mem_we), 32'd0);
        checkOutput("reset_re_drop", 32'(bus.mem_re), 32'd0);
        checkOutput("reset_ready",   32'(bus.req_ready), 32'd1);
        @(posedge clk); @(posedge clk); #2;
        rst = 0;
        repeat (4) @(negedge clk);
    endtask

    logic [31:0] rd, sa;
    logic        er;
    int          lat, wc;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);

        applyStimulus(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, er, rd, lat, sa, wc);
        checkOutput("sw_lat", 32'(lat), 32'd2);
        checkOutput("sw_addr", sa, 32'd4);
        checkOutput("sw_we_cycles", 32'(wc), 32'd1);
        checkOutput("sw_mem4", tb_mem[4], 32'hDEADBEEF);

        applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lw_lat", 32'(lat), 32'd2);
        checkOutput("lw_rdata", rd, 32'hDEADBEEF);

        applyStimulus(1, 2'b00, 0, 32'h11, 32'h000000A5, er, rd, lat, sa, wc);
        checkOutput("sb_lat", 32'(lat), 32'd3);
        checkOutput("sb_mem4", tb_mem[4], 32'hDEADA5EF);

        applyStimulus(0, 2'b00, 0, 32'h11, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lb_signed", rd, 32'hFFFFFFA5);
        applyStimulus(0, 2'b00, 1, 32'h11, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lbu", rd, 32'h000000A5);

        applyStimulus(1, 2'b01, 0, 32'h12, 32'h00001234, er, rd, lat, sa, wc);
        checkOutput("sh_mem4", tb_mem[4], 32'h1234A5EF);
        applyStimulus(0, 2'b01, 0, 32'h12, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lh_signed_hi", rd, 32'h00001234);
        applyStimulus(0, 2'b01, 0, 32'h10, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lh_signed_lo", rd, 32'hFFFFA5EF);
        applyStimulus(0, 2'b00, 1, 32'h13, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lbu_lane3", rd, 32'h00000012);
        applyStimulus(0, 2'b00, 0, 32'h10, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lb_lane0", rd, 32'hFFFFFFEF);

        applyStimulus(0, 2'b10, 0, 32'h13, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lw_mis_err", 32'(er), 32'd1);
        checkOutput("lw_mis_lat", 32'(lat), 32'd1);
        checkOutput("lw_mis_rdata", rd, 32'h0);
        applyStimulus(1, 2'b01, 0, 32'h21, 32'h0000BEEF, er, rd, lat, sa, wc);
        checkOutput("sh_mis_err", 32'(er), 32'd1);
        checkOutput("sh_mis_we", 32'(wc), 32'd0);
        checkOutput("sh_mis_mem8", tb_mem[8], 32'h0);
        applyStimulus(0, 2'b11, 0, 32'h20, 32'h0, er, rd, lat, sa, wc);
        checkOutput("size11_err", 32'(er), 32'd1);

        applyStimulus(1, 2'b00, 0, 32'h23, 32'hFFFFFF77, er, rd, lat, sa, wc);
        checkOutput("sb_lane3_mem8", tb_mem[8], 32'h77000000);
        applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, er, rd, lat, sa, wc);
        checkOutput("lw_mem8", rd, 32'h77000000);

        resetDuring(1, 2'b00, 32'h10, 32'h00000055);
        checkOutput("rst_rmw_mem4", tb_mem[4], 32'h1234A5EF);
        checkOutput("rst_rmw_ready", 32'(bus.req_ready), 32'd1);
        resetDuring(1, 2'b10, 32'h10, 32'h0BADF00D);
        checkOutput("rst_write_mem4", tb_mem[4], 32'h1234A5EF);

        applyStimulus(1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, er, rd, lat, sa, wc);
        applyStimulus(0, 2'b10, 0, 32'h3FC, 32'h0, er, rd, lat, sa, wc);
        checkOutput("top_word_addr", sa, 32'd255);
        checkOutput("top_word_rdata", rd, 32'hCAFEF00D);
        applyStimulus(0, 2'b10, 0, 32'h400, 32'h0, er, rd, lat, sa, wc);
`ifdef LSU_BOUNDS_CHECK_EN
        checkOutput("oob_err", 32'(er), 32'd1);
        checkOutput("oob_lat", 32'(lat), 32'd1);
`else
        checkOutput("oob_err", 32'(er), 32'd0);
        checkOutput("oob_addr", sa, 32'd256);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
